// File: rtl/fifo_drain_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_drain_arb_pkg
// Shared definitions for the FIFO drain arbiter:
//   - state_t       : arbiter state encoding (IDLE / BURST)
//   - clog2_min1()  : index/counter width helper, never returns less than 1
//   - DEF_*         : default parameter values used by the arbiter and rr_pick
// -----------------------------------------------------------------------------
package fifo_drain_arb_pkg;

    localparam int DEF_NPORT     = 4;
    localparam int DEF_DWIDTH    = 8;
    localparam int DEF_MAX_BURST = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Width needed to hold values 0..n-1, with a floor of one bit so that
    // degenerate sizes still produce a legal vector.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches the request vector starting
// at last+1 and wrapping modulo N; the first requester found wins.
// Ports:
//   req      in  N  request vector, bit i = port i requesting
//   last     in  W  most recently granted port
//   grant    out W  selected port (0 when nothing is requested)
//   any_req  out 1  at least one request is present
// -----------------------------------------------------------------------------
module rr_pick
    import fifo_drain_arb_pkg::*;
#(
    parameter  int N = DEF_NPORT,
    localparam int W = clog2_min1(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] grant,
    output logic         any_req
);

    logic [W-1:0] hi_idx;
    logic [W-1:0] lo_idx;
    logic         hi_hit;
    logic         lo_hit;

    // Two regions: ports above last (searched first) and ports at or below
    // last (the wrapped part). Scanning downward leaves the lowest requesting
    // index of each region in hi_idx / lo_idx.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // so no path leaves a value held and no latch is inferred.
        hi_idx = '0;
        lo_idx = '0;
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i > int'(last)) begin
                    hi_idx = W'(i);
                    hi_hit = 1'b1;
                end else begin
                    lo_idx = W'(i);
                    lo_hit = 1'b1;
                end
            end
        end
        grant   = hi_hit ? hi_idx : lo_idx;
        any_req = hi_hit | lo_hit;
    end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_drain_arbiter
// Drains NPORT FIFO read ports (all on rclk) into one registered valid/ready
// stream. Ports are served round-robin, up to MAX_BURST words per grant, with
// one arbitration cycle in IDLE before each burst.
//
// Optional build macro FIFO_DRAIN_ARB_PRIO0_EN: when defined, port 0 wins every
// arbitration in which it is non-empty; the others share round-robin only
// while port 0 is empty. Running bursts are never pre-empted.
//
// Ports:
//   rclk         in   1              read-domain clock
//   rrst         in   1              asynchronous active-high reset
//   enable       in   1              allow new grants (open burst completes)
//   fifo_rempty  in   NPORT          per-port empty flags
//   fifo_rdata   in   NPORT*DWIDTH   per-port head data, port i at [i*DWIDTH +: DWIDTH]
//   fifo_rinc    out  NPORT          per-port pop strobe, at most one bit high
//   out_valid    out  1              output word valid
//   out_ready    in   1              consumer accepts the word
//   out_data     out  DWIDTH         output word
//   out_src      out  SW             source port of out_data
//   busy         out  1              burst open or output word pending
// -----------------------------------------------------------------------------
module fifo_drain_arbiter
    import fifo_drain_arb_pkg::*;
#(
    parameter  int NPORT     = DEF_NPORT,
    parameter  int DWIDTH    = DEF_DWIDTH,
    parameter  int MAX_BURST = DEF_MAX_BURST,
    localparam int SW        = clog2_min1(NPORT),
    localparam int CW        = clog2_min1(MAX_BURST + 1)
) (
    input  logic                    rclk,
    input  logic                    rrst,
    input  logic                    enable,
    input  logic [NPORT-1:0]        fifo_rempty,
    input  logic [NPORT*DWIDTH-1:0] fifo_rdata,
    output logic [NPORT-1:0]        fifo_rinc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DWIDTH-1:0]       out_data,
    output logic [SW-1:0]           out_src,
    output logic                    busy
);

    state_t        state, state_next;
    logic [SW-1:0] grant, grant_next;
    logic [SW-1:0] last_grant, last_grant_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          pop;
    logic          grant_empty;
    logic [SW-1:0] rr_grant;
    logic          rr_any;
    logic [SW-1:0] pick_grant;

    rr_pick #(
        .N (NPORT)
    ) u_rr_pick (
        .req     (~fifo_rempty),
        .last    (last_grant),
        .grant   (rr_grant),
        .any_req (rr_any)
    );

`ifdef FIFO_DRAIN_ARB_PRIO0_EN
    // Port 0 overrides the rotating pointer whenever it has data.
    assign pick_grant = fifo_rempty[0] ? rr_grant : '0;
`else
    assign pick_grant = rr_grant;
`endif

    assign grant_empty = fifo_rempty[grant];

    always_comb begin
        state_next      = state;
        grant_next      = grant;
        cnt_next        = cnt;
        last_grant_next = last_grant;
        pop             = 1'b0;
        fifo_rinc       = '0;
        case (state)
            IDLE: begin
                if (enable && rr_any) begin
                    grant_next = pick_grant;
                    cnt_next   = '0;
                    state_next = BURST;
                end
            end
            BURST: begin
                // Pop when the granted FIFO has data and the output register
                // is free or being emptied this cycle.
                pop              = ~grant_empty & (~out_valid | out_ready);
                fifo_rinc[grant] = pop;
                if (pop) begin
                    cnt_next = cnt + 1'b1;
                end
                // An empty granted FIFO closes the burst even under stall.
                if ((pop && (cnt == CW'(MAX_BURST - 1))) || grant_empty) begin
                    state_next      = IDLE;
                    last_grant_next = grant;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state      <= IDLE;
            grant      <= '0;
            cnt        <= '0;
            last_grant <= SW'(NPORT - 1);
        end else begin
            // NOTE: registered state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of block order.
            state      <= state_next;
            grant      <= grant_next;
            cnt        <= cnt_next;
            last_grant <= last_grant_next;
        end
    end

    // Output register: a pop loads a new word (also covering the accept-and-
    // refill case for full throughput); an accept without a pop empties it.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= fifo_rdata[grant*DWIDTH +: DWIDTH];
            out_src   <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign busy = (state == BURST) | out_valid;

endmodule
